frequency_generator: RTL



---
 rtl/freq_gen_pkg.sv | 30 +++
 rtl/frequency_generator_if.sv | 34 +++
 rtl/serial_divider.sv | 61 ++++++
 rtl/frequency_generator.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/freq_gen_pkg.sv
`default_nettype none
// ============================================================================
// freq_gen_pkg: shared constants, FSM encoding and BCD helper.   Rev 1.0
// ============================================================================
package freq_gen_pkg;

  localparam int CLK_HZ_DEFAULT = 100_000_000;
  localparam int DIV_W_DEFAULT  = 26;
  localparam int BCD_DIGITS     = 4;
  localparam int BCD_W          = BCD_DIGITS * 4;
  localparam int BIN_W          = 14;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_DIVIDE  = 2'd2,
    ST_COMMIT  = 2'd3
  } state_t;

  function automatic logic bcd_valid(input logic [BCD_W-1:0] value);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (value[i*4 +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/frequency_generator_if.sv
`default_nettype none
// ============================================================================
// frequency_generator_if: setting/load/status/wave bundle.   Rev 1.0
// ============================================================================
interface frequency_generator_if;
  import freq_gen_pkg::*;

  logic [BCD_W-1:0] Frequency;
  logic             Load;
  logic             Busy;
  logic             Error;
  logic [BIN_W-1:0] Active_Freq;
  logic             Fxout;

  modport master (
    output Frequency,
    output Load,
    input  Busy,
    input  Error,
    input  Active_Freq,
    input  Fxout
  );

  modport slave (
    input  Frequency,
    input  Load,
    output Busy,
    output Error,
    output Active_Freq,
    output Fxout
  );

endinterface
`default_nettype wire

// File: rtl/serial_divider.sv
`default_nettype none
// ============================================================================
// serial_divider: restoring divider, one quotient bit per cycle.   Rev 1.0
// ============================================================================
module serial_divider #(
  parameter int DIV_W = 26,
  parameter int DVS_W = 14
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             start,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic [DIV_W-1:0] quotient,
  output logic             done
);

  localparam int c_CNT_W = $clog2(DIV_W + 1);

  logic [DIV_W-1:0]   r_acc;
  logic [DVS_W-1:0]   r_rem;
  logic [DVS_W-1:0]   r_dvs;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_run;

  logic [DVS_W:0]     w_trial;
  logic [DVS_W-1:0]   w_diff;
  logic               w_ge;

  // Dividend bits shift out of r_acc while quotient bits shift in behind them.
  assign w_trial = {r_rem, r_acc[DIV_W-1]};
  assign w_ge    = (w_trial >= {1'b0, r_dvs});
  assign w_diff  = w_trial[DVS_W-1:0] - r_dvs;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_acc <= '0;
      r_rem <= '0;
      r_dvs <= '0;
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (start) begin
      r_acc <= dividend;
      r_rem <= '0;
      r_dvs <= divisor;
      r_cnt <= c_CNT_W'(DIV_W);
      r_run <= 1'b1;
    end else if (r_run) begin
      r_rem <= w_ge ? w_diff : w_trial[DVS_W-1:0];
      r_acc <= {r_acc[DIV_W-2:0], w_ge};
      r_cnt <= r_cnt - c_CNT_W'(1);
      if (r_cnt == c_CNT_W'(1)) r_run <= 1'b0;
    end
  end

  // Flags the final iteration so the quotient is settled on the following cycle.
  assign done     = r_run && (r_cnt == c_CNT_W'(1));
  assign quotient = r_acc;

endmodule
`default_nettype wire

// File: rtl/frequency_generator.sv
`default_nettype none
// ============================================================================
// frequency_generator: BCD-programmed square-wave source, glitch-free retune. Rev 1.0
// ============================================================================
module frequency_generator
  import freq_gen_pkg::*;
#(
  parameter int CLK_HZ = CLK_HZ_DEFAULT,
  parameter int DIV_W  = DIV_W_DEFAULT
) (
  input  logic                  Clk,
  input  logic                  Rst,
  frequency_generator_if.slave  bus
);

  localparam logic [DIV_W-1:0] c_half_clk = DIV_W'(CLK_HZ / 2);
  localparam logic [1:0]       c_last_dig = 2'(BCD_DIGITS - 1);

  state_t           r_state;
  state_t           w_next;
  logic             r_busy;
  logic             r_err;
  logic [BCD_W-1:0] r_digits;
  logic [1:0]       r_dcnt;
  logic [BIN_W-1:0] r_bin;
  logic [BIN_W-1:0] r_active;

  logic [DIV_W-1:0] r_half;
  logic [DIV_W-1:0] r_pend;
  logic             r_pend_v;
  logic [DIV_W-1:0] r_cnt;
  logic             r_fx;

  logic             w_accept;
  logic             w_reject;
  logic             w_start;
  logic             w_commit;
  logic             w_div_done;
  logic [DIV_W-1:0] w_quot;
  logic [3:0]       w_digit;
  logic [BIN_W-1:0] w_bin_next;

  assign w_digit    = r_digits[BCD_W-1 -: 4];
  assign w_bin_next = (r_bin << 3) + (r_bin << 1) + BIN_W'(w_digit);

  serial_divider #(
    .DIV_W (DIV_W),
    .DVS_W (BIN_W)
  ) u_div (
    .Clk      (Clk),
    .Rst      (Rst),
    .start    (w_start),
    .dividend (c_half_clk),
    .divisor  (w_bin_next),
    .quotient (w_quot),
    .done     (w_div_done)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_reject = 1'b0;
    w_start  = 1'b0;
    w_commit = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.Load) begin
          if (bcd_valid(bus.Frequency)) begin
            w_accept = 1'b1;
            w_next   = ST_CONVERT;
          end else begin
            w_reject = 1'b1;
          end
        end
      end
      ST_CONVERT: begin
        if (r_dcnt == c_last_dig) begin
          if (w_bin_next == '0) begin
            w_next = ST_COMMIT;
          end else begin
            w_start = 1'b1;
            w_next  = ST_DIVIDE;
          end
        end
      end
      ST_DIVIDE: begin
        if (w_div_done) w_next = ST_COMMIT;
      end
      ST_COMMIT: begin
        w_commit = 1'b1;
        w_next   = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Setting capture, MSD-first BCD accumulate and status flags.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_busy   <= 1'b0;
      r_err    <= 1'b0;
      r_digits <= '0;
      r_dcnt   <= '0;
      r_bin    <= '0;
      r_active <= '0;
    end else begin
      if (w_accept) begin
        r_busy   <= 1'b1;
        r_err    <= 1'b0;
        r_digits <= bus.Frequency;
        r_dcnt   <= '0;
        r_bin    <= '0;
      end
      if (w_reject) r_err <= 1'b1;
      if (r_state == ST_CONVERT) begin
        r_bin    <= w_bin_next;
        r_digits <= {r_digits[BCD_W-5:0], 4'h0};
        r_dcnt   <= r_dcnt + 2'd1;
      end
      if (w_commit) begin
        r_busy   <= 1'b0;
        r_active <= r_bin;
      end
    end
  end

  // Wave engine: a new half-period is only adopted at a toggle boundary,
  // except when starting from stopped, where there is no edge to protect.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_half   <= '0;
      r_pend   <= '0;
      r_pend_v <= 1'b0;
      r_cnt    <= '0;
      r_fx     <= 1'b0;
    end else begin
      if (r_half != '0) begin
        if (r_cnt == r_half - DIV_W'(1)) begin
          r_cnt <= '0;
          r_fx  <= ~r_fx;
          if (r_pend_v) begin
            r_half   <= r_pend;
            r_pend_v <= 1'b0;
          end
        end else begin
          r_cnt <= r_cnt + DIV_W'(1);
        end
      end
      if (w_commit) begin
        if (r_bin == '0) begin
          r_half   <= '0;
          r_cnt    <= '0;
          r_fx     <= 1'b0;
          r_pend_v <= 1'b0;
        end else if (r_half == '0) begin
          r_half <= w_quot;
          r_cnt  <= '0;
        end else begin
          r_pend   <= w_quot;
          r_pend_v <= 1'b1;
        end
      end
    end
  end

  assign bus.Busy        = r_busy;
  assign bus.Error       = r_err;
  assign bus.Active_Freq = r_active;
  assign bus.Fxout       = r_fx;

endmodule
`default_nettype wire
